// File: rtl/vixen_trace_pkg.sv
// Shared definitions for the vixen trace capture: event kind codes and entry field widths.
package vixen_trace_pkg;

    typedef enum logic [2:0] {
        TK_EXEC    = 3'd0,
        TK_STORE   = 3'd1,
        TK_HALT    = 3'd2,
        TK_TRAP    = 3'd3,
        TK_TIMEOUT = 3'd4
    } trace_kind_e;

    // Entry = {kind[2:0], stamp[TS_W-1:0], a[15:0], b[15:0], f[3:0]}
    localparam int KIND_W        = 3;
    localparam int A_W           = 16;
    localparam int B_W           = 16;
    localparam int F_W           = 4;
    localparam int ENTRY_FIXED_W = KIND_W + A_W + B_W + F_W;

endpackage

// File: rtl/vixen_trace_if.sv
// CPU-side event signals and drain port of the trace unit.
// Filter bounds exist only when VIXEN_TRACE_FILTER_EN is defined.
interface vixen_trace_if #(
    parameter int DEPTH = 16,
    parameter int TS_W  = 32
);
    import vixen_trace_pkg::*;

    logic                          exec_valid;
    logic [15:0]                   exec_pc;
    logic [15:0]                   exec_op;
    logic [3:0]                    exec_flags;
    logic                          st_valid;
    logic                          st_wide;
    logic [15:0]                   st_addr;
    logic [15:0]                   st_data;
    logic                          halt;
    logic                          trap;
    logic                          rd_ready;
    logic                          rd_valid;
    logic [ENTRY_FIXED_W+TS_W-1:0] rd_data;
    logic [$clog2(DEPTH):0]        count;
    logic [15:0]                   overflow;
    logic                          stopped;
    logic [2:0]                    stop_kind;
`ifdef VIXEN_TRACE_FILTER_EN
    logic [15:0]                   filt_lo;
    logic [15:0]                   filt_hi;
`endif

    modport master (
        output exec_valid, exec_pc, exec_op, exec_flags,
        output st_valid, st_wide, st_addr, st_data, halt, trap, rd_ready,
`ifdef VIXEN_TRACE_FILTER_EN
        output filt_lo, filt_hi,
`endif
        input  rd_valid, rd_data, count, overflow, stopped, stop_kind
    );

    modport slave (
        input  exec_valid, exec_pc, exec_op, exec_flags,
        input  st_valid, st_wide, st_addr, st_data, halt, trap, rd_ready,
`ifdef VIXEN_TRACE_FILTER_EN
        input  filt_lo, filt_hi,
`endif
        output rd_valid, rd_data, count, overflow, stopped, stop_kind
    );

endinterface

// File: rtl/vixen_trace_fifo.sv
// Dual-write / single-read circular buffer with show-ahead head and drop reporting.
// A forced last write that would be dropped overwrites the newest stored entry instead.
module vixen_trace_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 71
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr0_valid,
    input  logic [W-1:0]             wr0_data,
    input  logic                     wr1_valid,
    input  logic [W-1:0]             wr1_data,
    input  logic                     wr_force,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [W-1:0]             rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic [1:0]               drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]   count_reg;

    logic          pop, acc0, acc1, term_drop;
    logic [AW:0]   free;
    logic          p0_en;
    logic [AW-1:0] p0_addr;
    logic [W-1:0]  p0_data;

    always_comb begin
        pop       = rd_ready && (count_reg != '0);
        free      = (AW+1)'(DEPTH) - count_reg + (AW+1)'(pop);
        acc0      = wr0_valid && (free != '0);
        acc1      = wr1_valid && (free >= (AW+1)'(2));
        term_drop = wr_force && (wr1_valid ? !acc1 : !acc0);
        drop      = {1'b0, wr0_valid && !acc0} + {1'b0, wr1_valid && !acc1};
        // Overwrite lands on this cycle's accepted write if any, else the previous tail.
        p0_en     = acc0 || term_drop;
        p0_addr   = (term_drop && !acc0) ? (wr_ptr_reg - PTR_ONE) : wr_ptr_reg;
        p0_data   = term_drop ? (wr1_valid ? wr1_data : wr0_data) : wr0_data;
    end

    always_ff @(posedge clk) begin
        if (p0_en) mem[p0_addr] <= p0_data;
        if (acc1)  mem[wr_ptr_reg + PTR_ONE] <= wr1_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + AW'(acc0) + AW'(acc1);
            rd_ptr_reg <= rd_ptr_reg + AW'(pop);
            count_reg  <= count_reg - (AW+1)'(pop) + (AW+1)'(acc0) + (AW+1)'(acc1);
        end
    end

    assign rd_valid = (count_reg != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr_reg] : '0;
    assign count    = count_reg;

endmodule

// File: rtl/vixen_trace.sv
// Trace capture top: stamp counter, RUN/STOPPED FSM, watchdog, entry packing and PC filter.
// Optional PC-range filter enabled by VIXEN_TRACE_FILTER_EN.
module vixen_trace
    import vixen_trace_pkg::*;
#(
    parameter int          DEPTH   = 16,
    parameter int          TS_W    = 32,
    parameter int unsigned TIMEOUT = 0
) (
    input logic          clk,
    input logic          reset,
    vixen_trace_if.slave bus
);
    localparam int EW = ENTRY_FIXED_W + TS_W;
    localparam logic [0:0]  ST_RUN     = 1'b0;
    localparam logic [0:0]  ST_STOPPED = 1'b1;
    localparam logic [31:0] WD_LIMIT   = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    logic [0:0]      state_reg;
    logic [TS_W-1:0] stamp_reg;
    logic [31:0]     wd_reg;
    logic [15:0]     last_pc_reg;
    logic [15:0]     ovf_reg;
    logic [2:0]      stop_kind_reg;

    logic            run, filt_ok, is_term, rec_exec, rec_store, to_fire, sec_valid;
    trace_kind_e     term_kind;
    logic [15:0]     store_b;
    logic [EW-1:0]   exec_entry, store_entry, term_entry, to_entry, sec_data;
    logic            wr0_valid, wr1_valid, wr_force;
    logic [EW-1:0]   wr0_data, wr1_data;
    logic [1:0]      drop;
    logic [16:0]     ovf_sum;

`ifdef VIXEN_TRACE_FILTER_EN
    assign filt_ok = (bus.filt_lo <= bus.exec_pc) && (bus.exec_pc <= bus.filt_hi);
`else
    assign filt_ok = 1'b1;
`endif

    always_comb begin
        run       = (state_reg == ST_RUN);
        is_term   = run && bus.exec_valid && (bus.halt || bus.trap);
        term_kind = bus.trap ? TK_TRAP : TK_HALT;
        rec_exec  = run && bus.exec_valid && filt_ok;
        rec_store = rec_exec && bus.st_valid && !(bus.halt || bus.trap);
        to_fire   = run && (TIMEOUT != 0) && !bus.exec_valid && (wd_reg == WD_LIMIT);

        store_b     = bus.st_wide ? bus.st_data : {8'h00, bus.st_data[7:0]};
        exec_entry  = {TK_EXEC, stamp_reg, bus.exec_pc, bus.exec_op, bus.exec_flags};
        store_entry = {TK_STORE, stamp_reg, bus.st_addr, store_b, {bus.st_wide, 3'b000}};
        term_entry  = {term_kind, stamp_reg, bus.exec_pc, bus.exec_op, bus.exec_flags};
        to_entry    = {TK_TIMEOUT, stamp_reg, last_pc_reg, 16'h0000, 4'h0};

        // Second slot carries the STORE or terminating entry; compact it down when EXEC is filtered.
        sec_valid = is_term || rec_store;
        sec_data  = is_term ? term_entry : store_entry;
        wr0_valid = rec_exec || sec_valid || to_fire;
        wr0_data  = rec_exec ? exec_entry : (to_fire ? to_entry : sec_data);
        wr1_valid = rec_exec && sec_valid;
        wr1_data  = sec_data;
        wr_force  = is_term || to_fire;

        ovf_sum   = {1'b0, ovf_reg} + {15'b0, drop};
    end

    vixen_trace_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr0_valid (wr0_valid),
        .wr0_data  (wr0_data),
        .wr1_valid (wr1_valid),
        .wr1_data  (wr1_data),
        .wr_force  (wr_force),
        .rd_ready  (bus.rd_ready),
        .rd_valid  (bus.rd_valid),
        .rd_data   (bus.rd_data),
        .count     (bus.count),
        .drop      (drop)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_RUN;
            stamp_reg     <= '0;
            wd_reg        <= '0;
            last_pc_reg   <= '0;
            ovf_reg       <= '0;
            stop_kind_reg <= '0;
        end else begin
            stamp_reg <= stamp_reg + TS_W'(1);
            ovf_reg   <= ovf_sum[16] ? 16'hFFFF : ovf_sum[15:0];
            if (run) begin
                wd_reg <= bus.exec_valid ? 32'd0 : wd_reg + 32'd1;
                if (bus.exec_valid) last_pc_reg <= bus.exec_pc;
                if (is_term) begin
                    state_reg     <= ST_STOPPED;
                    stop_kind_reg <= term_kind;
                end else if (to_fire) begin
                    state_reg     <= ST_STOPPED;
                    stop_kind_reg <= TK_TIMEOUT;
                end
            end
        end
    end

    assign bus.overflow  = ovf_reg;
    assign bus.stopped   = (state_reg == ST_STOPPED);
    assign bus.stop_kind = stop_kind_reg;

endmodule

// File: tb/tb_vixen_trace.sv
// Directed self-checking bench for vixen_trace (DEPTH=4, TIMEOUT=10); filter cases need VIXEN_TRACE_FILTER_EN.
module tb_vixen_trace;
    localparam int DEPTH = 4;
    localparam int TS_W  = 32;
    localparam int EW    = 39 + TS_W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    vixen_trace_if #(.DEPTH(DEPTH), .TS_W(TS_W)) bus();

    vixen_trace #(.DEPTH(DEPTH), .TS_W(TS_W), .TIMEOUT(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        ev;
        logic [15:0] pc;
        logic [15:0] op;
        logic [3:0]  fl;
        logic        sv;
        logic        sw;
        logic [15:0] sa;
        logic [15:0] sd;
        int          n;
        logic [2:0]  k1;
        logic [15:0] a1;
        logic [15:0] b1;
        logic [3:0]  f1;
    } vec_t;

    int total = 0;
    int bad   = 0;
    logic [31:0]   ms;
    logic [EW-1:0] expq[$];
    vec_t          vecs[7];

    function automatic logic [EW-1:0] mk(logic [2:0] k, logic [31:0] s, logic [15:0] a,
                                         logic [15:0] b, logic [3:0] f);
        return {k, s, a, b, f};
    endfunction

    task automatic check(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // One clock of the currently driven inputs; any entry popped this cycle is compared in order.
    task automatic step();
        logic [EW-1:0] e;
        @(negedge clk);
        if (bus.rd_valid && bus.rd_ready) begin
            if (expq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_pop: got %h want none", bus.rd_data);
            end else begin
                e = expq.pop_front();
                check("pop", 128'(bus.rd_data), 128'(e));
            end
        end
        @(posedge clk);
        #1;
        ms = ms + 32'd1;
    endtask

    task automatic idle_in();
        bus.exec_valid = 1'b0; bus.exec_pc = '0; bus.exec_op = '0; bus.exec_flags = '0;
        bus.st_valid = 1'b0; bus.st_wide = 1'b0; bus.st_addr = '0; bus.st_data = '0;
        bus.halt = 1'b0; bus.trap = 1'b0;
    endtask

    task automatic exec_in(logic [15:0] pc, logic [15:0] op, logic [3:0] fl);
        idle_in();
        bus.exec_valid = 1'b1; bus.exec_pc = pc; bus.exec_op = op; bus.exec_flags = fl;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_in();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        ms = 32'd0;
        expq.delete();
    endtask

    initial begin
        vecs[0] = '{1'b1, 16'h0000, 16'h1111, 4'h0, 1'b0, 1'b0, 16'h0, 16'h0, 1, 3'd0, 16'h0, 16'h0, 4'h0};
        vecs[1] = '{1'b1, 16'h0002, 16'h2222, 4'h8, 1'b0, 1'b0, 16'h0, 16'h0, 1, 3'd0, 16'h0, 16'h0, 4'h0};
        vecs[2] = '{1'b1, 16'h0004, 16'h3333, 4'h5, 1'b0, 1'b0, 16'h0, 16'h0, 1, 3'd0, 16'h0, 16'h0, 4'h0};
        vecs[3] = '{1'b1, 16'h0006, 16'h4444, 4'h2, 1'b1, 1'b0, 16'h8000, 16'h12AB, 2, 3'd1, 16'h8000, 16'h00AB, 4'h0};
        vecs[4] = '{1'b1, 16'h0008, 16'h5555, 4'h1, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 2, 3'd1, 16'h1234, 16'hBEEF, 4'h8};
        vecs[5] = '{1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b1, 16'h5555, 16'h5555, 0, 3'd0, 16'h0, 16'h0, 4'h0};
        vecs[6] = '{1'b1, 16'h000A, 16'h6666, 4'hF, 1'b1, 1'b0, 16'hFFFE, 16'hFF80, 2, 3'd1, 16'hFFFE, 16'h0080, 4'h0};

        ms = 32'd0;
        bus.rd_ready = 1'b0;
`ifdef VIXEN_TRACE_FILTER_EN
        bus.filt_lo = 16'h0000;
        bus.filt_hi = 16'hFFFF;
`endif
        idle_in();
        #12;
        check("rst_rd_valid", 128'(bus.rd_valid), 128'(0));
        check("rst_rd_data", 128'(bus.rd_data), 128'(0));
        check("rst_count", 128'(bus.count), 128'(0));
        check("rst_overflow", 128'(bus.overflow), 128'(0));
        check("rst_stopped", 128'(bus.stopped), 128'(0));
        check("rst_stop_kind", 128'(bus.stop_kind), 128'(0));

        // Table: consecutive EXEC stamps and STORE packing
        do_reset();
        bus.rd_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            idle_in();
            bus.exec_valid = vecs[i].ev; bus.exec_pc = vecs[i].pc;
            bus.exec_op = vecs[i].op; bus.exec_flags = vecs[i].fl;
            bus.st_valid = vecs[i].sv; bus.st_wide = vecs[i].sw;
            bus.st_addr = vecs[i].sa; bus.st_data = vecs[i].sd;
            if (vecs[i].n >= 1) expq.push_back(mk(3'd0, ms, vecs[i].pc, vecs[i].op, vecs[i].fl));
            if (vecs[i].n == 2) expq.push_back(mk(vecs[i].k1, ms, vecs[i].a1, vecs[i].b1, vecs[i].f1));
            step();
            idle_in();
            step();
            step();
        end
        step();
        check("table_drained", 128'(expq.size()), 128'(0));
        check("table_overflow", 128'(bus.overflow), 128'(0));
        check("table_stopped", 128'(bus.stopped), 128'(0));

        // Overflow with terminating HALT overwriting the newest entry
        do_reset();
        bus.rd_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exec_in(16'h0100 + 16'(2 * k), 16'hA000 + 16'(k), 4'(k));
            if (k < 3) expq.push_back(mk(3'd0, ms, 16'h0100 + 16'(2 * k), 16'hA000 + 16'(k), 4'(k)));
            step();
        end
        exec_in(16'h010A, 16'hB000, 4'hF);
        bus.halt = 1'b1;
        expq.push_back(mk(3'd2, ms, 16'h010A, 16'hB000, 4'hF));
        step();
        idle_in();
        check("ovf_count", 128'(bus.count), 128'(4));
        check("ovf_overflow", 128'(bus.overflow), 128'(3));
        check("ovf_stopped", 128'(bus.stopped), 128'(1));
        check("ovf_stop_kind", 128'(bus.stop_kind), 128'(2));
        check("ovf_head", 128'(bus.rd_data), 128'(mk(3'd0, 32'd0, 16'h0100, 16'hA000, 4'h0)));
        exec_in(16'h0999, 16'h9999, 4'h9);
        bus.rd_ready = 1'b1;
        repeat (6) step();
        check("ovf_drained", 128'(expq.size()), 128'(0));
        check("ovf_count_end", 128'(bus.count), 128'(0));

        // Watchdog: TIMEOUT entry 10 cycles after last exec
        do_reset();
        bus.rd_ready = 1'b1;
        exec_in(16'h0040, 16'hC000, 4'h2);
        expq.push_back(mk(3'd0, ms, 16'h0040, 16'hC000, 4'h2));
        expq.push_back(mk(3'd4, ms + 32'd10, 16'h0040, 16'h0000, 4'h0));
        step();
        idle_in();
        for (int i = 0; i < 30 && !bus.stopped; i++) step();
        check("to_stopped", 128'(bus.stopped), 128'(1));
        check("to_stop_kind", 128'(bus.stop_kind), 128'(4));
        exec_in(16'h0050, 16'h1234, 4'h1);
        bus.st_valid = 1'b1;
        repeat (4) step();
        idle_in();
        check("to_drained", 128'(expq.size()), 128'(0));
        check("to_count_end", 128'(bus.count), 128'(0));

        // halt+trap together: TRAP wins, no STORE
        do_reset();
        bus.rd_ready = 1'b1;
        exec_in(16'h0200, 16'hAAAA, 4'h3);
        bus.halt = 1'b1; bus.trap = 1'b1;
        bus.st_valid = 1'b1; bus.st_addr = 16'h4000; bus.st_data = 16'h5678;
        expq.push_back(mk(3'd0, ms, 16'h0200, 16'hAAAA, 4'h3));
        expq.push_back(mk(3'd3, ms, 16'h0200, 16'hAAAA, 4'h3));
        step();
        idle_in();
        repeat (3) step();
        check("trap_stop_kind", 128'(bus.stop_kind), 128'(3));
        check("trap_stopped", 128'(bus.stopped), 128'(1));
        check("trap_drained", 128'(expq.size()), 128'(0));

        // Asynchronous reset mid-stream, then capture resumes from stamp 0
        do_reset();
        bus.rd_ready = 1'b0;
        exec_in(16'h0010, 16'h0101, 4'h0);
        step();
        step();
        idle_in();
        check("mid_count_before", 128'(bus.count), 128'(2));
        #3 reset = 1'b1;
        #1;
        check("mid_rd_valid", 128'(bus.rd_valid), 128'(0));
        check("mid_count", 128'(bus.count), 128'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        ms = 32'd0;
        bus.rd_ready = 1'b1;
        exec_in(16'h0300, 16'hD00D, 4'h1);
        expq.push_back(mk(3'd0, 32'd0, 16'h0300, 16'hD00D, 4'h1));
        step();
        idle_in();
        step();
        step();
        check("resume_drained", 128'(expq.size()), 128'(0));
        check("resume_stopped", 128'(bus.stopped), 128'(0));

`ifdef VIXEN_TRACE_FILTER_EN
        begin
            logic [15:0] fpc[4];
            logic        fwant[4];
            fpc[0] = 16'h000E; fwant[0] = 1'b0;
            fpc[1] = 16'h0010; fwant[1] = 1'b1;
            fpc[2] = 16'h0020; fwant[2] = 1'b1;
            fpc[3] = 16'h0022; fwant[3] = 1'b0;
            do_reset();
            bus.rd_ready = 1'b1;
            bus.filt_lo = 16'h0010;
            bus.filt_hi = 16'h0020;
            for (int i = 0; i < 4; i++) begin
                exec_in(fpc[i], 16'h7000, 4'h0);
                if (fwant[i]) expq.push_back(mk(3'd0, ms, fpc[i], 16'h7000, 4'h0));
                step();
                idle_in();
                step();
            end
            bus.filt_lo = 16'h0030;
            bus.filt_hi = 16'h0020;
            exec_in(16'h0025, 16'h7001, 4'h0);
            step();
            idle_in();
            step();
            step();
            check("filt_drained", 128'(expq.size()), 128'(0));
            bus.filt_lo = 16'h0000;
            bus.filt_hi = 16'hFFFF;
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
